// File: rtl/crossbar_output_stage.sv
// crossbar_output_stage: steers reserved inputs onto granted outputs through 2-entry skid buffers
// Define CROSSBAR_STATS_EN to add per-output pushed-flit counters on flit_count_bus.
module crossbar_output_stage #(
  parameter int INPUTS = 4,
  parameter int OUTPUTS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int REQUEST_WIDTH = $clog2(INPUTS),
  parameter int CNT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [INPUTS*DATA_WIDTH-1:0]     data_in_bus,
  input  logic [INPUTS-1:0]                valid_in_bus,
  output logic [INPUTS-1:0]                ready_in_bus,
  input  logic [OUTPUTS*REQUEST_WIDTH-1:0] routeSelect,
  input  logic [OUTPUTS-1:0]               outputBusy,
  output logic [OUTPUTS*DATA_WIDTH-1:0]    data_out_bus,
  output logic [OUTPUTS-1:0]               valid_out_bus,
  input  logic [OUTPUTS-1:0]               ready_out_bus,
  output logic                             conflict_err
`ifdef CROSSBAR_STATS_EN
  ,
  output logic [OUTPUTS*CNT_WIDTH-1:0]     flit_count_bus
`endif
);
  logic [REQUEST_WIDTH-1:0] sel [OUTPUTS];
  logic [DATA_WIDTH-1:0] pdata [OUTPUTS];
  logic [OUTPUTS-1:0] win, push, full;
  logic conflict;
  // a busy output loses its grant when a lower-index busy output already claims the same input
  always_comb begin
    win = outputBusy;
    push = '0;
    ready_in_bus = '0;
    conflict = 1'b0;
    for (int o = 0; o < OUTPUTS; o++) begin
      sel[o] = routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH];
      pdata[o] = '0;
    end
    for (int o = 0; o < OUTPUTS; o++)
      for (int p = 0; p < o; p++)
        if (outputBusy[p] && outputBusy[o] && sel[p] == sel[o]) begin
          win[o] = 1'b0;
          conflict = 1'b1;
        end
    for (int o = 0; o < OUTPUTS; o++)
      for (int i = 0; i < INPUTS; i++)
        if (win[o] && sel[o] == REQUEST_WIDTH'(i)) begin
          push[o] = valid_in_bus[i] & ~full[o];
          pdata[o] = data_in_bus[i*DATA_WIDTH +: DATA_WIDTH];
          ready_in_bus[i] = ~full[o];
        end
  end
  always_ff @(posedge clk)
    conflict_err <= rst & (conflict_err | conflict);
  for (genvar k = 0; k < OUTPUTS; k++) begin : g_out
    logic [1:0] cnt;
    logic [DATA_WIDTH-1:0] head, tail;
    logic pop;
    assign pop = (cnt != 2'd0) & ready_out_bus[k];
    assign full[k] = cnt == 2'd2;
    assign valid_out_bus[k] = cnt != 2'd0;
    assign data_out_bus[k*DATA_WIDTH +: DATA_WIDTH] = head;
    // push is never asserted when full, so push+pop only occurs at count 1
    always_ff @(posedge clk)
      if (!rst) begin
        cnt <= '0;
        head <= '0;
        tail <= '0;
      end else begin
        cnt <= cnt + {1'b0, push[k]} - {1'b0, pop};
        head <= (pop && cnt == 2'd2) ? tail : (push[k] && (cnt == 2'd0 || pop)) ? pdata[k] : head;
        tail <= (push[k] && !pop && cnt == 2'd1) ? pdata[k] : tail;
      end
`ifdef CROSSBAR_STATS_EN
    logic [CNT_WIDTH-1:0] flits;
    always_ff @(posedge clk)
      flits <= !rst ? '0 : flits + CNT_WIDTH'(push[k]);
    assign flit_count_bus[k*CNT_WIDTH +: CNT_WIDTH] = flits;
`else
    if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    end
`endif
  end
endmodule
